// File: rtl/pipeline_wb.sv
// pipeline_wb: MEM/WB pipeline register, load alignment/extension, write-back mux and retire counter
module pipeline_wb #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_WB,
  input  logic                 rst_WB,
  input  logic                 stall_WB,
  input  logic                 flush_WB,
  input  logic                 valid_in_WB,
  input  logic                 RegWrite_in_WB,
  input  logic [4:0]           Rd_addr_in_WB,
  input  logic [1:0]           MemtoReg_in_WB,
  input  logic [2:0]           Fun3_in_WB,
  input  logic [31:0]          ALU_out_in_WB,
  input  logic [31:0]          Mem_data_in_WB,
  input  logic [31:0]          PC4_in_WB,
  input  logic [31:0]          Imm_in_WB,
  output logic                 RegWrite_out_WB,
  output logic [4:0]           Rd_addr_out_WB,
  output logic [31:0]          Wt_data_out_WB,
  output logic                 valid_out_WB,
  output logic [CNT_WIDTH-1:0] retired_cnt_WB
);
  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  m2r;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [31:0] imm;
  } wb_t;
  wb_t                 wb_d, wb_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 retire;
  logic [7:0]           b;
  logic [15:0]          h;
  logic [31:0]          ld;
  // next MEM/WB contents: reset and flush load a bubble, stall holds, otherwise capture
  always_comb begin
    wb_d = (rst_WB | flush_WB) ? '0 : stall_WB ? wb_q :
           '{valid_in_WB, RegWrite_in_WB, Rd_addr_in_WB, MemtoReg_in_WB, Fun3_in_WB,
             ALU_out_in_WB, Mem_data_in_WB, PC4_in_WB, Imm_in_WB};
    retire = wb_q.valid & (~stall_WB | flush_WB);
    cnt_d = rst_WB ? '0 : cnt_q + {{(CNT_WIDTH-1){1'b0}}, retire};
  end
  // state registers
  always_ff @(posedge clk_WB) begin
    wb_q  <= wb_d;
    cnt_q <= cnt_d;
  end
  // load extraction and write-back source select from registered fields only
  always_comb begin
    b = wb_q.alu[1:0] == 2'd0 ? wb_q.mem[7:0] : wb_q.alu[1:0] == 2'd1 ? wb_q.mem[15:8] :
        wb_q.alu[1:0] == 2'd2 ? wb_q.mem[23:16] : wb_q.mem[31:24];
    h = wb_q.alu[1] ? wb_q.mem[31:16] : wb_q.mem[15:0];
    ld = wb_q.f3 == 3'b000 ? {{24{b[7]}}, b} : wb_q.f3 == 3'b100 ? {24'b0, b} :
         wb_q.f3 == 3'b001 ? {{16{h[15]}}, h} : wb_q.f3 == 3'b101 ? {16'b0, h} : wb_q.mem;
    Wt_data_out_WB = wb_q.m2r == 2'b00 ? wb_q.alu : wb_q.m2r == 2'b01 ? ld :
                     wb_q.m2r == 2'b10 ? wb_q.pc4 : wb_q.imm;
  end
  assign RegWrite_out_WB = wb_q.rw & wb_q.valid & (wb_q.rd != 5'd0);
  assign Rd_addr_out_WB  = wb_q.rd;
  assign valid_out_WB    = wb_q.valid;
  assign retired_cnt_WB  = cnt_q;
endmodule

// File: tb/tb_pipeline_wb.sv
// tb_pipeline_wb: directed vectors for the write-back stage
module tb_pipeline_wb;
  logic        clk = 0, rst = 0, stall = 0, flush = 0;
  logic        vin = 0, rwin = 0;
  logic [4:0]  rdin = 0;
  logic [1:0]  m2rin = 0;
  logic [2:0]  f3in = 0;
  logic [31:0] aluin = 0, memin = 0, pc4in = 0, immin = 0;
  logic        rw, vout;
  logic [4:0]  rd;
  logic [31:0] wt;
  logic [3:0]  cnt;
  int          n_vec = 0, n_bad = 0, ec = 0;

  pipeline_wb #(.CNT_WIDTH(4)) dut (
    .clk_WB(clk), .rst_WB(rst), .stall_WB(stall), .flush_WB(flush),
    .valid_in_WB(vin), .RegWrite_in_WB(rwin), .Rd_addr_in_WB(rdin),
    .MemtoReg_in_WB(m2rin), .Fun3_in_WB(f3in), .ALU_out_in_WB(aluin),
    .Mem_data_in_WB(memin), .PC4_in_WB(pc4in), .Imm_in_WB(immin),
    .RegWrite_out_WB(rw), .Rd_addr_out_WB(rd), .Wt_data_out_WB(wt),
    .valid_out_WB(vout), .retired_cnt_WB(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] r, input logic [1:0] m,
                       input logic [2:0] f, input logic [31:0] a);
    vin = v; rwin = w; rdin = r; m2rin = m; f3in = f; aluin = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    drive(1, 1, 5'd3, 2'b01, 3'b000, 32'h1);
    memin = 32'h8381F07F; pc4in = 32'h104; immin = 32'hABCDE000;
    step(); step();
    chk("rst_rw", {31'b0, rw}, 0);
    chk("rst_valid", {31'b0, vout}, 0);
    chk("rst_wt", wt, 0);
    chk("rst_cnt", {28'b0, cnt}, 0);
    rst = 0;

    drive(1, 1, 5'd1, 2'b01, 3'b000, 32'h1); step();
    chk("lb", wt, 32'hFFFFFFF0);
    chk("cnt_first", {28'b0, cnt}, 0);
    drive(1, 1, 5'd1, 2'b01, 3'b100, 32'h1); step();
    chk("lbu", wt, 32'h000000F0);
    drive(1, 1, 5'd1, 2'b01, 3'b001, 32'h2); step();
    chk("lh", wt, 32'hFFFF8381);
    drive(1, 1, 5'd1, 2'b01, 3'b101, 32'h3); step();
    chk("lhu_a0_ignored", wt, 32'h00008381);
    drive(1, 1, 5'd1, 2'b01, 3'b101, 32'h0); step();
    chk("lhu_low", wt, 32'h0000F07F);
    drive(1, 1, 5'd1, 2'b01, 3'b000, 32'h3); step();
    chk("lb_b3", wt, 32'hFFFFFF83);
    drive(1, 1, 5'd1, 2'b01, 3'b010, 32'h1); step();
    chk("lw", wt, 32'h8381F07F);
    drive(1, 1, 5'd1, 2'b01, 3'b011, 32'h2); step();
    chk("f3_other", wt, 32'h8381F07F);
    ec = 7;
    chk("cnt_loads", {28'b0, cnt}, ec[31:0]);

    drive(1, 1, 5'd5, 2'b00, 3'b000, 32'h11); step(); ec++;
    chk("mux_alu", wt, 32'h11);
    chk("mux_rw", {31'b0, rw}, 1);
    chk("mux_rd", {27'b0, rd}, 5);
    drive(1, 1, 5'd5, 2'b10, 3'b000, 32'h11); step(); ec++;
    chk("mux_pc4", wt, 32'h104);
    drive(1, 1, 5'd5, 2'b11, 3'b000, 32'h11); step(); ec++;
    chk("mux_imm", wt, 32'hABCDE000);

    drive(1, 1, 5'd0, 2'b00, 3'b000, 32'h22); step(); ec++;
    chk("x0_rw", {31'b0, rw}, 0);
    chk("x0_wt", wt, 32'h22);
    drive(1, 0, 5'd4, 2'b00, 3'b000, 32'h33); step(); ec++;
    chk("x0_cnt", {28'b0, cnt}, ec[31:0]);
    chk("norw_rw", {31'b0, rw}, 0);
    drive(0, 1, 5'd6, 2'b00, 3'b000, 32'h44); step(); ec++;
    chk("inv_rw", {31'b0, rw}, 0);
    chk("inv_valid", {31'b0, vout}, 0);

    drive(1, 1, 5'd7, 2'b00, 3'b000, 32'hA7); step();
    chk("a_cnt", {28'b0, cnt}, ec[31:0]);
    stall = 1;
    drive(1, 1, 5'd9, 2'b10, 3'b000, 32'h55);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rd", {27'b0, rd}, 7);
      chk("stall_wt", wt, 32'hA7);
      chk("stall_rw", {31'b0, rw}, 1);
      chk("stall_cnt", {28'b0, cnt}, ec[31:0]);
    end
    flush = 1; step(); ec++;
    chk("flush_valid", {31'b0, vout}, 0);
    chk("flush_rw", {31'b0, rw}, 0);
    chk("flush_rd", {27'b0, rd}, 0);
    chk("flush_wt", wt, 0);
    chk("flush_cnt", {28'b0, cnt}, ec[31:0]);
    step();
    chk("flush_empty_cnt", {28'b0, cnt}, ec[31:0]);
    stall = 0; flush = 0;

    drive(1, 1, 5'd8, 2'b00, 3'b000, 32'h66); step();
    stall = 1; rst = 1; step(); ec = 0;
    chk("rst_stall_valid", {31'b0, vout}, 0);
    chk("rst_stall_cnt", {28'b0, cnt}, 0);
    stall = 0; rst = 0;

    drive(1, 1, 5'd2, 2'b00, 3'b000, 32'h1);
    for (int k = 1; k <= 18; k++) begin
      step();
      chk("wrap", {28'b0, cnt}, (k - 1) % 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_wb.md
Name: pipeline_wb

Overview:
Write-back stage of the 5-stage pipelined CPU. It contains the MEM/WB pipeline register, load-data alignment and extension, and the write-back source mux. It drives the register-file write port (RegWrite, Rd_addr, Wt_data) consumed by the decode stage. It also keeps a retired-instruction counter used for debug display.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk_WB  input  1  stage clock; all state updates on posedge.
rst_WB  input  1  reset; synchronous, active-high.
stall_WB  input  1  hold the MEM/WB register contents.
flush_WB  input  1  replace the MEM/WB register contents with a bubble.
valid_in_WB  input  1  incoming MEM-stage slot holds a real instruction.
RegWrite_in_WB  input  1  incoming instruction writes rd.
Rd_addr_in_WB  input  5  incoming destination register.
MemtoReg_in_WB  input  2  write-back source: 00 ALU, 01 load data, 10 PC+4, 11 immediate.
Fun3_in_WB  input  3  load width/sign (funct3).
ALU_out_in_WB  input  32  ALU result; also the load address.
Mem_data_in_WB  input  32  raw aligned word read from data memory.
PC4_in_WB  input  32  PC+4 of the incoming instruction.
Imm_in_WB  input  32  immediate (lui).
RegWrite_out_WB  output  1  register-file write enable.
Rd_addr_out_WB  output  5  register-file write address.
Wt_data_out_WB  output  32  register-file write data.
valid_out_WB  output  1  WB slot holds a real instruction.
retired_cnt_WB  output  CNT_WIDTH  count of retired instructions.

Behaviour:
- Clock and reset: one clock, clk_WB. Reset is synchronous and active-high on rst_WB.
- Pipeline register update, evaluated on each posedge in priority order:
  - rst_WB: all fields cleared to 0, including valid, RegWrite, rd and data fields, and retired_cnt_WB cleared to 0.
  - else flush_WB: bubble loaded (valid=0, RegWrite=0, rd=0, MemtoReg=00, data fields 0). flush beats stall.
  - else stall_WB: all fields hold.
  - else: all *_in_WB inputs captured.
- Latency: inputs captured at edge N are visible on the outputs after edge N. Outputs are combinational from registered fields only; there is no input-to-output combinational path.
- Write enable:
  - RegWrite_out_WB = RegWrite_q & valid_q & (rd_q != 0). Writes to x0 are never issued.
  - Rd_addr_out_WB = rd_q unconditionally.
  - valid_out_WB = valid_q.
- Load extraction uses addr = ALU_q[1:0] and Fun3_q:
  - 000 LB: byte addr from Mem_data_q, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword selected by addr[1] (addr[0] ignored), sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW and all other funct3 values: full word, addr ignored.
- Wt_data_out_WB by MemtoReg_q:
  - 00: ALU_q.
  - 01: extracted load data.
  - 10: PC4_q.
  - 11: Imm_q.
  - Wt_data_out_WB is driven regardless of the write enable.
- Retired counter:
  - Retire event on an edge = valid_q & (!stall_WB | flush_WB) & !rst_WB. The current instruction leaves the stage either when it is replaced or when it is flushed.
  - retired_cnt_WB increments by 1 on each retire event.
  - Wraps modulo 2^CNT_WIDTH with no saturation.
- During a stall the held instruction keeps asserting RegWrite_out_WB every cycle. The re-write of the same value is harmless and intended.
- Reset asserted mid-stall or mid-flush: reset wins. The bubble and a zero counter appear after the reset edge.

Test Plan:
1. Reset: hold rst_WB 2 cycles with arbitrary inputs -> RegWrite_out_WB=0, valid_out_WB=0, Wt_data_out_WB=0, retired_cnt_WB=0.
2. Loads: Mem_data=0x8381F07F, ALU_out low bits=01.
   - LB -> 0xFFFFFFF0; LBU -> 0x000000F0.
   - With addr=10: LH -> 0xFFFF8381; LHU -> 0x00008381.
   - LW -> 0x8381F07F.
3. Mux sources: MemtoReg 00/10/11 with ALU=0x11, PC4=0x104, Imm=0xABCDE000 -> Wt_data matches each source; rd=5, RegWrite=1 -> RegWrite_out_WB=1.
4. x0 suppression: rd=0, RegWrite=1, valid=1 -> RegWrite_out_WB=0; retired_cnt_WB still increments.
5. Stall then flush:
   - Capture instr A (rd=7), then stall 3 cycles -> outputs hold A, counter unchanged.
   - Assert stall and flush together -> bubble next cycle, counter +1.
6. Counter wrap: CNT_WIDTH=4, 17 back-to-back valid instructions -> retired_cnt_WB reads 15 then 0 then 1.
